// File: rtl/vga_pkg.sv
// Shared constants, slot encoding and display address helper for the
// VGA frame-buffer arbiter.
package vga_pkg;

    localparam int FB_W     = 320;
    localparam int FB_H     = 240;
    localparam int FB_SIZE  = FB_W * FB_H;
    localparam int PIX_W    = 12;
    localparam int ADDR_W   = 17;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_DISP = 2'd1,
        SLOT_WR   = 2'd2
    } slot_e;

    // Linear frame-buffer address of (x, y): y*320 + x, built as
    // (y << 8) + (y << 6) + x so no multiplier is needed.
    function automatic logic [ADDR_W-1:0] fb_disp_addr(
        input logic [8:0] x,
        input logic [8:0] y
    );
        logic [ADDR_W-1:0] x_ext;
        logic [ADDR_W-1:0] y_ext;
        x_ext = {{(ADDR_W-9){1'b0}}, x};
        y_ext = {{(ADDR_W-9){1'b0}}, y};
        return (y_ext << 8) + (y_ext << 6) + x_ext;
    endfunction

endpackage

// File: rtl/vga_pix_pipe.sv
// Display output pipeline: two-stage delay of valid/hsync/vsync and of the
// display-slot flag, plus the pixel hold register that repeats each fetched
// pixel for the odd column of its pair.
module vga_pix_pipe #(
    parameter int PIX_W = vga_pkg::PIX_W
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic             disp_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic [PIX_W-1:0] rdata_i,
    output logic [PIX_W-1:0] rgb_o,
    output logic             hsync_o,
    output logic             vsync_o
);

    logic             valid_d1_q;
    logic             valid_d2_q;
    logic             disp_d1_q;
    logic             disp_d2_q;
    logic             hs_d1_q;
    logic             hs_d2_q;
    logic             vs_d1_q;
    logic             vs_d2_q;
    logic [PIX_W-1:0] hold_q;
    logic [PIX_W-1:0] hold_d;

    // Read data arrives two cycles after a display decision; take it then,
    // otherwise keep showing the last fetched pixel.
    always_comb begin
        hold_d = hold_q;
        if (disp_d2_q) begin
            hold_d = rdata_i;
        end
    end

    // Delay line; syncs idle high so the monitor sees no pulse out of reset.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            valid_d1_q <= 1'b0;
            valid_d2_q <= 1'b0;
            disp_d1_q  <= 1'b0;
            disp_d2_q  <= 1'b0;
            hs_d1_q    <= 1'b1;
            hs_d2_q    <= 1'b1;
            vs_d1_q    <= 1'b1;
            vs_d2_q    <= 1'b1;
            hold_q     <= '0;
        end else begin
            valid_d1_q <= valid_i;
            valid_d2_q <= valid_d1_q;
            disp_d1_q  <= disp_i;
            disp_d2_q  <= disp_d1_q;
            hs_d1_q    <= hsync_i;
            hs_d2_q    <= hs_d1_q;
            vs_d1_q    <= vsync_i;
            vs_d2_q    <= vs_d1_q;
            hold_q     <= hold_d;
        end
    end

    assign rgb_o   = valid_d2_q ? hold_d : '0;
    assign hsync_o = hs_d2_q;
    assign vsync_o = vs_d2_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display fetch owns even active pixels,
// one writer gets the remaining slots through a req/ack handshake.
//
// Writer handshake: the writer raises wr_req with wr_addr/wr_data and holds
// all three stable until it samples wr_ack high. wr_ack is a one-cycle pulse
// issued together with the registered RAM access; the cycle after an ack the
// request is ignored so a request still held during the ack is not taken twice.
module vga_fb_arbiter #(
    parameter int FB_W           = vga_pkg::FB_W,
    parameter int FB_H           = vga_pkg::FB_H,
    parameter int PIX_W          = vga_pkg::PIX_W,
    parameter int ADDR_W         = vga_pkg::ADDR_W,
    parameter bit WR_VBLANK_ONLY = 1'b0
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic              valid,
    input  logic              v_blank,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [PIX_W-1:0]  ram_wdata,
    input  logic [PIX_W-1:0]  ram_rdata,
    output logic [PIX_W-1:0]  rgb,
    output logic              hsync,
    output logic              vsync
);

    import vga_pkg::*;

    // One extra bit so the limit still fits when FB_W*FB_H == 2**ADDR_W.
    localparam logic [ADDR_W:0] FB_LIMIT = (ADDR_W+1)'(FB_W * FB_H);

    slot_e             slot;
    logic              grant;
    logic              in_range;

    logic [ADDR_W-1:0] ram_addr_q;
    logic [ADDR_W-1:0] ram_addr_d;
    logic              ram_we_q;
    logic              ram_we_d;
    logic [PIX_W-1:0]  ram_wdata_q;
    logic [PIX_W-1:0]  ram_wdata_d;
    logic              wr_ack_q;
    logic              wr_ack_d;
    logic              wr_err_q;
    logic              wr_err_d;

    // Vertical doubling drops the line LSB.
    logic              unused_vcnt_lsb;
    assign unused_vcnt_lsb = v_cnt[0];

    // Slot owner for this cycle: even active pixels fetch, everything else
    // may write (only during vertical blanking in the vblank-only build).
    always_comb begin
        slot = SLOT_IDLE;
        if (valid && !h_cnt[0]) begin
            slot = SLOT_DISP;
        end else if (!WR_VBLANK_ONLY || v_blank) begin
            slot = SLOT_WR;
        end
    end

    assign grant    = (slot == SLOT_WR) && wr_req && !wr_ack_q;
    assign in_range = ({1'b0, wr_addr} < FB_LIMIT);

    // Next RAM access and handshake state; registered at the end of the
    // decision cycle. The shift-add address helper assumes FB_W == 320.
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        wr_ack_d    = 1'b0;
        wr_err_d    = wr_err_q;
        if (slot == SLOT_DISP) begin
            ram_addr_d = ADDR_W'(fb_disp_addr(h_cnt[9:1], v_cnt[9:1]));
        end else if (grant) begin
            ram_addr_d  = wr_addr;
            ram_wdata_d = wr_data;
            ram_we_d    = in_range;
            wr_ack_d    = 1'b1;
            if (!in_range) begin
                wr_err_d = 1'b1;
            end
        end
    end

    // RAM port and handshake registers.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            wr_ack_q    <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            wr_ack_q    <= wr_ack_d;
            wr_err_q    <= wr_err_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign wr_ack    = wr_ack_q;
    assign wr_err    = wr_err_q;

    vga_pix_pipe #(
        .PIX_W (PIX_W)
    ) u_pix_pipe (
        .pclk    (pclk),
        .reset   (reset),
        .valid_i (valid),
        .disp_i  (slot == SLOT_DISP),
        .hsync_i (hsync_in),
        .vsync_i (vsync_in),
        .rdata_i (ram_rdata),
        .rgb_o   (rgb),
        .hsync_o (hsync),
        .vsync_o (vsync)
    );

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural frame-buffer RAM,
// a request-holding writer and an expected-access scoreboard.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;

    localparam int AW = 17;
    localparam int PW = 12;

    // ---------------- clock / reset ----------------
    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic          reset;
    logic [9:0]    h_cnt, v_cnt;
    logic          valid, v_blank, hsync_in, vsync_in;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_data;

    logic          wr_ack, wr_err, ram_we, hsync, vsync;
    logic [AW-1:0] ram_addr;
    logic [PW-1:0] ram_wdata, ram_rdata, rgb;

    logic          vb_wr_ack;
    logic          unused_vb_err, unused_vb_we, unused_vb_hs, unused_vb_vs;
    logic [AW-1:0] unused_vb_addr;
    logic [PW-1:0] unused_vb_wdata, unused_vb_rgb;
    logic [PW-1:0] vb_ram_rdata;
    assign vb_ram_rdata = '0;

    vga_fb_arbiter #(.WR_VBLANK_ONLY(1'b0)) dut (
        .pclk(pclk), .reset(reset), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
        .v_blank(v_blank), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_err(wr_err), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .rgb(rgb),
        .hsync(hsync), .vsync(vsync)
    );

    vga_fb_arbiter #(.WR_VBLANK_ONLY(1'b1)) dut_vb (
        .pclk(pclk), .reset(reset), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
        .v_blank(v_blank), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(vb_wr_ack), .wr_err(unused_vb_err), .ram_addr(unused_vb_addr),
        .ram_we(unused_vb_we), .ram_wdata(unused_vb_wdata), .ram_rdata(vb_ram_rdata),
        .rgb(unused_vb_rgb), .hsync(unused_vb_hs), .vsync(unused_vb_vs)
    );

    // Frame buffer preloaded with pixel value == address, 1-cycle read latency.
    logic [PW-1:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < 76800; i++) mem[i] <= PW'(i);
    end
    always @(posedge pclk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- driver state ----------------
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [PW-1:0] data;
    } wr_t;

    wr_t             wq[$];
    logic [AW+PW:0]  exp_q[$];   // {we, addr, data}
    bit              ack_seen = 1'b0;
    bit              use_vb   = 1'b0;
    int              cyc      = 0;
    int              ack_cnt  = 0;
    int              we_cnt   = 0;
    int              vb_ack_cnt = 0;
    int              ack_cyc_q[$];

    logic            t_rst_n;
    logic [9:0]      t_h, t_v;
    logic            t_valid, t_vblank, t_hs, t_vs;

    task automatic push_write(input logic [AW-1:0] a, input logic [PW-1:0] d, input bit sb);
        wr_t w;
        w.addr = a;
        w.data = d;
        wq.push_back(w);
        if (sb) exp_q.push_back({(a < 17'd76800), a, d});
    endtask

    // One clock: apply inputs after the edge, then sample at the falling edge.
    task automatic drive_cycle();
        logic [AW+PW:0] e;
        @(posedge pclk);
        #1;
        cyc++;
        if (ack_seen) begin
            wq.delete(0);
            ack_seen = 1'b0;
        end
        reset    = t_rst_n;
        h_cnt    = t_h;
        v_cnt    = t_v;
        valid    = t_valid;
        v_blank  = t_vblank;
        hsync_in = t_hs;
        vsync_in = t_vs;
        if (wq.size() > 0) begin
            wr_req  = 1'b1;
            wr_addr = wq[0].addr;
            wr_data = wq[0].data;
        end else begin
            wr_req  = 1'b0;
        end
        @(negedge pclk);
        if (use_vb ? vb_wr_ack : wr_ack) ack_seen = 1'b1;
        if (!use_vb && wr_ack) begin
            ack_cnt++;
            ack_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("sb_queue_nonempty", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("sb_we",    ram_we,    e[AW+PW]);
                check("sb_addr",  ram_addr,  e[AW+PW-1:PW]);
                check("sb_wdata", ram_wdata, e[PW-1:0]);
            end
        end
        if (ram_we) we_cnt++;
        if (vb_wr_ack) vb_ack_cnt++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int a0, w0, b0;
        bit got_ack;

        t_rst_n = 1'b0; t_h = '0; t_v = '0; t_valid = 1'b0; t_vblank = 1'b0;
        t_hs = 1'b0; t_vs = 1'b0;
        h_cnt = '0; v_cnt = '0; valid = 1'b0; v_blank = 1'b0;
        hsync_in = 1'b0; vsync_in = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);

        // Reset values
        check("rst_rgb",       rgb,       0);
        check("rst_hsync",     hsync,     1);
        check("rst_vsync",     vsync,     1);
        check("rst_wr_ack",    wr_ack,    0);
        check("rst_wr_err",    wr_err,    0);
        check("rst_ram_we",    ram_we,    0);
        check("rst_ram_addr",  ram_addr,  0);
        check("rst_ram_wdata", ram_wdata, 0);

        // Release with syncs low: outputs stay high two cycles, then follow.
        t_rst_n = 1'b1;
        drive_cycle();
        check("rel_hsync_c0", hsync, 1);
        drive_cycle();
        check("rel_hsync_c1", hsync, 1);
        drive_cycle();
        check("rel_hsync_c2", hsync, 0);
        check("rel_vsync_c2", vsync, 0);
        check("rel_rgb",      rgb,   0);
        check("rel_no_ack",   ack_cnt, 0);
        t_hs = 1'b1;
        t_vs = 1'b1;

        // Full line scan at v_cnt = 3 (frame-buffer row 1).
        for (int c = 0; c < 644; c++) begin
            t_valid = (c < 640);
            t_h     = (c < 640) ? 10'(c) : 10'd0;
            t_v     = (c < 640) ? 10'd3  : 10'd0;
            t_hs    = !(c >= 10 && c < 20);
            drive_cycle();
            if (c >= 2 && c <= 641) check("scan_rgb", rgb, 320 + ((c - 2) >> 1));
            if (c == 642 || c == 643) check("rgb_after_valid", rgb, 0);
            if (c == 11) check("hsync_before_pulse", hsync, 1);
            if (c == 12) check("hsync_pulse_start",  hsync, 0);
            if (c == 21) check("hsync_pulse_end",    hsync, 0);
            if (c == 22) check("hsync_after_pulse",  hsync, 1);
        end
        t_hs = 1'b1;

        // Write during active video, request raised on a display slot.
        a0 = ack_cnt;
        w0 = we_cnt;
        for (int c = 0; c < 210; c++) begin
            t_valid = 1'b1;
            t_h     = 10'(c);
            t_v     = 10'd0;
            if (c == 4) push_write(17'd100, 12'hABC, 1'b1);
            drive_cycle();
            if (c == 5) check("ack_waits_disp_slot", wr_ack, 0);
            if (c == 6) begin
                check("ack_active",     wr_ack,   1);
                check("we_active",      ram_we,   1);
                check("addr_active",    ram_addr, 100);
            end
            if (c == 202) check("readback_even", rgb, 12'hABC);
            if (c == 203) check("readback_odd",  rgb, 12'hABC);
            if (c == 204) check("readback_next", rgb, 12'h065);
        end
        check("active_ack_count", ack_cnt - a0, 1);
        check("active_we_count",  we_cnt - w0,  1);
        check("active_q_drained", wq.size(),    0);

        // Back-to-back writes during blanking, last in-range and first out-of-range.
        t_valid = 1'b0; t_h = '0; t_v = '0; t_vblank = 1'b1;
        repeat (2) drive_cycle();
        a0 = ack_cnt;
        w0 = we_cnt;
        ack_cyc_q.delete();
        push_write(17'd1000,  12'h111, 1'b1);
        push_write(17'd1001,  12'h222, 1'b1);
        push_write(17'd1002,  12'h333, 1'b1);
        push_write(17'd76799, 12'h7FF, 1'b1);
        push_write(17'd76800, 12'h123, 1'b1);
        for (int c = 0; c < 14; c++) begin
            drive_cycle();
            if (c == 8) check("err_clear_last_valid", wr_err, 0);
            if (c == 9) begin
                check("oor_ack",  wr_ack, 1);
                check("oor_we",   ram_we, 0);
                check("err_set",  wr_err, 1);
            end
        end
        check("blank_ack_count", ack_cnt - a0, 5);
        check("blank_we_count",  we_cnt - w0,  4);
        check("blank_ack_q_len", ack_cyc_q.size(), 5);
        for (int i = 1; i < ack_cyc_q.size(); i++)
            check("ack_gap", ack_cyc_q[i] - ack_cyc_q[i-1], 2);
        push_write(17'd55, 12'h456, 1'b1);
        repeat (4) drive_cycle();
        check("err_sticky", wr_err, 1);

        // Reset between decision and ack drops the ack; held request retries.
        push_write(17'd2000, 12'h5A5, 1'b1);
        drive_cycle();
        reset   = 1'b0;
        t_rst_n = 1'b0;
        #1;
        check("err_cleared_by_reset", wr_err, 0);
        drive_cycle();
        check("ack_dropped_by_reset", wr_ack, 0);
        t_rst_n = 1'b1;
        got_ack = 1'b0;
        for (int c = 0; c < 4 && !got_ack; c++) begin
            drive_cycle();
            if (wr_ack) got_ack = 1'b1;
        end
        check("ack_after_reset", got_ack, 1);
        repeat (2) drive_cycle();
        check("sb_all_consumed", exp_q.size(), 0);

        // Vblank-only build: no grants in active video or horizontal blanking.
        use_vb   = 1'b1;
        t_vblank = 1'b0;
        b0 = vb_ack_cnt;
        push_write(17'd3000, 12'h0F0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            t_valid = 1'b1; t_h = 10'(c); t_v = 10'd10;
            drive_cycle();
        end
        for (int c = 0; c < 6; c++) begin
            t_valid = 1'b0; t_h = '0; t_v = '0;
            drive_cycle();
        end
        check("vb_no_ack_before_blank", vb_ack_cnt - b0, 0);
        t_vblank = 1'b1;
        drive_cycle();
        check("vb_ack_not_early", vb_wr_ack, 0);
        got_ack = 1'b0;
        for (int c = 0; c < 2 && !got_ack; c++) begin
            drive_cycle();
            if (vb_wr_ack) got_ack = 1'b1;
        end
        check("vb_ack_within_2", got_ack, 1);
        repeat (3) drive_cycle();
        check("vb_single_ack", vb_ack_cnt - b0, 1);
        use_vb = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port frame-buffer RAM, 320x240 x 12-bit, between the VGA display fetch and one pixel writer (drawing or game logic).
- The display is scanned at 2x pixel doubling from the 640x480 timing counters.
- Display reads own the RAM on even active pixels. The writer gets every other slot through a req/ack handshake.
- Outputs the RGB pixel and delays hsync/vsync so all three reach the DAC aligned.

Parameters:
- FB_W, 320, frame-buffer width in pixels.
- FB_H, 240, frame-buffer height in lines.
- PIX_W, 12, pixel width (4:4:4 RGB).
- ADDR_W, 17, RAM address width; must satisfy 2^ADDR_W >= FB_W*FB_H.
- WR_VBLANK_ONLY, 0, when 1 the writer is granted only while v_valid is low across the whole frame blanking (line_cnt >= 480).

Ports:
- pclk  in  1  pixel clock, 25 MHz.
- reset  in  1  asynchronous, active-low reset.
- h_cnt  in  10  horizontal pixel index; 0 outside the active region.
- v_cnt  in  10  vertical line index; 0 outside the active region.
- valid  in  1  active-video flag.
- v_blank  in  1  high while the line counter is at or above 480.
- hsync_in  in  1  raw hsync from the timing generator.
- vsync_in  in  1  raw vsync from the timing generator.
- wr_req  in  1  writer request.
- wr_addr  in  ADDR_W  linear frame-buffer address.
- wr_data  in  PIX_W  pixel to write.
- wr_ack  out  1  one-cycle pulse: write accepted.
- wr_err  out  1  sticky flag: an out-of-range write was seen.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  PIX_W  RAM write data.
- ram_rdata  in  PIX_W  RAM read data, valid 1 cycle after the address.
- rgb  out  PIX_W  pixel to the DAC; 0 outside the active region.
- hsync  out  1  hsync_in delayed by 2 cycles.
- vsync  out  1  vsync_in delayed by 2 cycles.

Behaviour:
- Reset (reset low, asynchronous) values:
  - rgb = 0, wr_ack = 0, wr_err = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0.
  - hsync and vsync pipeline registers = 1.
- Slot decision, combinational each cycle:
  - DISP slot when valid and h_cnt[0] == 0.
  - Otherwise WR slot.
  - When WR_VBLANK_ONLY = 1, a WR slot additionally requires v_blank = 1. Without it the slot is IDLE.
- DISP slot:
  - ram_addr = (v_cnt >> 1) * FB_W + (h_cnt >> 1).
  - Implement the multiply by 320 as a shift-add: (y << 8) + (y << 6).
  - ram_we = 0.
- WR slot with wr_req = 1:
  - ram_addr = wr_addr, ram_wdata = wr_data.
  - ram_we = 1 if wr_addr < FB_W*FB_H; otherwise ram_we = 0 and wr_err is set (sticky until reset).
  - wr_ack = 1 in the same cycle, registered outputs only.
- Output registering and writer handshake rules:
  - ram_* and wr_ack are driven from registers loaded at the clock edge that ends the decision cycle, so the effective RAM access happens the cycle after the decision.
  - The writer must hold wr_req, wr_addr and wr_data stable until it sees wr_ack.
  - wr_ack is never asserted on two consecutive cycles for the same request. After wr_ack the block ignores wr_req for one cycle, so a held req is not written twice.
- Display pipeline, where cycle 0 is the decision cycle:
  - Cycle 1: ram_addr is presented.
  - Cycle 2: ram_rdata is captured into a pixel hold register.
  - A delayed valid (2 stages) gates rgb: rgb = hold when valid_d2, else 0.
  - The odd pixel of each pair reuses the hold register, giving 2x horizontal doubling. Vertical doubling comes from v_cnt >> 1.
  - hsync and vsync pass through 2 flops, so they align with rgb.
- Write bandwidth:
  - During active video, at most 1 write per 2 cycles.
  - During blanking, 1 write per 2 cycles (ack, gap, ack).
  - No starvation when WR_VBLANK_ONLY = 0: the worst-case wait for a grant is 2 cycles.
- Boundary cases:
  - h_cnt = 639 is odd, so that cycle is a WR slot.
  - The valid 1->0 edge leaves the last pixel held for exactly 1 output cycle.
  - Reset mid-write drops the pending ack; the writer must re-request.
  - wr_req rising in the same cycle as a DISP slot waits for the next slot; no ack is issued.

Decomposition:
- Shared package vga_pkg holds:
  - constants FB_W, FB_H, FB_SIZE, PIX_W, ADDR_W;
  - the 640/480 active-area constants;
  - a slot enum {SLOT_IDLE, SLOT_DISP, SLOT_WR}.
- One natural sub-module, vga_pix_pipe: the 2-stage valid/hsync/vsync delay plus the pixel hold register.

Test Plan:
- Reset release with wr_req = 0: rgb = 0 and hsync = vsync = 1 until their inputs propagate; wr_ack is never asserted.
- RAM preloaded with addr = pixel value; scan v_cnt = 3, h_cnt = 0..639: rgb at output cycle h+2 = 320*1 + (h >> 1) for every h.
- wr_req held with wr_addr = 100, data = 12'hABC during active video: exactly one wr_ack, ram_we pulses once with addr 100. A later display read of (x = 100, y = 0) returns 12'hABC.
- wr_addr = 76800: wr_ack pulses, ram_we stays 0, wr_err = 1 and stays 1 until reset.
- WR_VBLANK_ONLY = 1, wr_req raised at v_cnt = 10: no ack until v_blank rises, then an ack within 2 cycles.
- Back-to-back requests in blanking: acks spaced exactly 2 cycles apart; no duplicate write per request.
